// File: rtl/vga_sync_rx.sv
// Receive side of the VGA timing path: measures line/frame periods of an incoming
// sync stream, locks onto stable timing and regenerates per-pixel coordinates.
module vga_sync_rx #(
    parameter int CNT_W       = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk0,
    input  logic             rst_n,
    input  logic             clk_div2,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic             blank_n,
    output logic             pixel_valid,
    output logic [CNT_W-1:0] pos_x,
    output logic [CNT_W-1:0] pos_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             locked,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {SEARCH, MEASURE, TRAIN, LOCKED} state_t;

    state_t           state;
    logic             hs_d, vs_d, bl_d, line_act;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_meas, v_meas, y_cnt, ref_h, ref_v;
    logic [2:0]       match_cnt;

    logic             hfall, vfall, h_to, v_to, h_bad, v_bad;
    logic [CNT_W:0]   h_inc, v_inc;
    logic [CNT_W-1:0] h_sat, v_sat, h_cnt_nxt, v_cnt_nxt, h_meas_nxt, v_meas_nxt;
    logic [3:0]       match_inc;

    always_comb begin
        hfall      = hs_d & ~h_sync;
        vfall      = vs_d & ~v_sync;
        h_inc      = {1'b0, h_cnt} + {{CNT_W{1'b0}}, 1'b1};
        v_inc      = {1'b0, v_cnt} + {{CNT_W{1'b0}}, hfall};
        h_sat      = h_inc[CNT_W] ? CNT_MAX : h_inc[CNT_W-1:0];
        v_sat      = v_inc[CNT_W] ? CNT_MAX : v_inc[CNT_W-1:0];
        h_cnt_nxt  = hfall ? '0 : h_sat;
        v_cnt_nxt  = vfall ? '0 : v_sat;
        h_meas_nxt = hfall ? h_sat : h_meas;
        v_meas_nxt = vfall ? v_sat : v_meas;
        // A counter pinned at its ceiling means the sync it waits for has vanished.
        h_to       = ~hfall & (h_sat == CNT_MAX);
        v_to       = ~vfall & (v_sat == CNT_MAX);
        h_bad      = hfall & (h_meas_nxt != ref_h);
        v_bad      = vfall & (v_meas_nxt != ref_v);
        match_inc  = {1'b0, match_cnt} + 4'd1;
    end

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state       <= SEARCH;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            bl_d        <= 1'b0;
            line_act    <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_meas      <= '0;
            v_meas      <= '0;
            y_cnt       <= '0;
            ref_h       <= '0;
            ref_v       <= '0;
            match_cnt   <= '0;
            pixel_valid <= 1'b0;
            pos_x       <= '0;
            pos_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            h_total     <= '0;
            v_total     <= '0;
        end else if (!clk_div2) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs_d        <= h_sync;
            vs_d        <= v_sync;
            bl_d        <= blank_n;
            h_cnt       <= h_cnt_nxt;
            v_cnt       <= v_cnt_nxt;
            h_meas      <= h_meas_nxt;
            v_meas      <= v_meas_nxt;
            line_start  <= hfall;
            frame_start <= 1'b0;

            pixel_valid <= blank_n;
            if (blank_n) begin
                pos_x <= bl_d ? pos_x + 1'b1 : '0;
                pos_y <= y_cnt;
            end
            // Only lines that carried visible pixels advance the row index.
            if (vfall)
                y_cnt <= '0;
            else if (hfall && line_act && y_cnt != CNT_MAX)
                y_cnt <= y_cnt + 1'b1;
            if (blank_n)
                line_act <= 1'b1;
            else if (hfall)
                line_act <= 1'b0;

            if (h_to || v_to) begin
                state  <= SEARCH;
                locked <= 1'b0;
            end else begin
                unique case (state)
                    SEARCH: if (vfall) state <= MEASURE;
                    MEASURE: if (vfall) begin
                        ref_h     <= h_meas_nxt;
                        ref_v     <= v_meas_nxt;
                        match_cnt <= '0;
                        state     <= TRAIN;
                    end
                    TRAIN: begin
                        if (h_bad || v_bad) begin
                            state <= SEARCH;
                        end else if (vfall) begin
                            match_cnt <= match_inc[2:0];
                            if (match_inc == 4'(LOCK_FRAMES)) begin
                                locked  <= 1'b1;
                                h_total <= ref_h;
                                v_total <= ref_v;
                                state   <= LOCKED;
                            end
                        end
                    end
                    LOCKED: begin
                        if (h_bad || v_bad) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                        end else if (vfall) begin
                            frame_start <= 1'b1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboarded bench for vga_sync_rx on a reduced 40x20 raster (24x12 visible)
// so several lock/unlock cycles fit in a short run.
module tb_vga_sync_rx;
    localparam int CNT_W = 10;
    localparam int H = 40, HS = 4, HA0 = 8, HACT = 24;
    localparam int V = 20, VS = 2, VA0 = 5, VACT = 12;

    logic clk0 = 1'b0, rst_n = 1'b0, clk_div2 = 1'b0;
    logic h_sync = 1'b1, v_sync = 1'b1, blank_n = 1'b0;
    logic pixel_valid, line_start, frame_start, locked;
    logic [CNT_W-1:0] pos_x, pos_y, h_total, v_total;

    int n_chk = 0, n_fail = 0;
    logic [2:0]         pl_q[$];
    logic [2*CNT_W-1:0] px_q[$];
    logic               tk_q = 1'b0;
    logic [2:0]         pe;
    logic [2*CNT_W-1:0] xe;

    always #5 clk0 = ~clk0;

    vga_sync_rx #(.CNT_W(CNT_W), .LOCK_FRAMES(2)) dut (
        .clk0(clk0), .rst_n(rst_n), .clk_div2(clk_div2),
        .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n),
        .pixel_valid(pixel_valid), .pos_x(pos_x), .pos_y(pos_y),
        .line_start(line_start), .frame_start(frame_start), .locked(locked),
        .h_total(h_total), .v_total(v_total)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one pop per tick, pulses must be absent on every non-tick cycle.
    always @(posedge clk0) tk_q <= clk_div2 & rst_n;
    always @(negedge clk0) begin
        if (tk_q) begin
            if (pl_q.size() == 0) begin
                check("tick_q_underflow", 1, 0);
            end else begin
                pe = pl_q.pop_front();
                check("pixel_valid", pixel_valid, pe[2]);
                check("line_start", line_start, pe[1]);
                check("frame_start", frame_start, pe[0]);
                if (pe[2]) begin
                    if (px_q.size() == 0) begin
                        check("px_q_underflow", 1, 0);
                    end else begin
                        xe = px_q.pop_front();
                        check("pos_x", pos_x, xe[2*CNT_W-1:CNT_W]);
                        check("pos_y", pos_y, xe[CNT_W-1:0]);
                    end
                end
            end
        end else begin
            check("pulse_idle", {line_start, frame_start}, 0);
        end
    end

    task automatic tick(input logic hs, input logic vs, input logic bl,
                        input logic ls, input logic fs, input int ex, input int ey);
        h_sync = hs; v_sync = vs; blank_n = bl; clk_div2 = 1'b1;
        pl_q.push_back({bl, ls, fs});
        if (bl) px_q.push_back({CNT_W'(ex), CNT_W'(ey)});
        @(posedge clk0); #1;
        clk_div2 = 1'b0;
        @(posedge clk0); #1;
    endtask

    task automatic send_px(input int hx, input int vy, input bit fs_en);
        logic bl;
        bl = (hx >= HA0) && (hx < HA0 + HACT) && (vy >= VA0) && (vy < VA0 + VACT);
        tick(hx >= HS, vy >= VS, bl, hx == 0, fs_en && hx == 0 && vy == 0, hx - HA0, vy - VA0);
    endtask

    task automatic send_line(input int vy, input int lo, input int hi, input bit fs_en);
        for (int hx = lo; hx < hi; hx++) send_px(hx, vy, fs_en);
    endtask

    task automatic send_rows(input int vlo, input int vhi, input bit fs_en, input int short_vy);
        for (int vy = vlo; vy < vhi; vy++) send_line(vy, 0, (vy == short_vy) ? H - 1 : H, fs_en);
    endtask

    task automatic check_lock(input string name, input logic l, input int ht, input int vt);
        check({name, "_locked"}, locked, l);
        check({name, "_h_total"}, h_total, ht);
        check({name, "_v_total"}, v_total, vt);
    endtask

    initial begin
        repeat (3) @(posedge clk0);
        @(negedge clk0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pos", {pos_x, pos_y}, 0);
        check("rst_pulses", {line_start, frame_start}, 0);
        check_lock("rst", 0, 0, 0);
        @(posedge clk0); #1;
        rst_n = 1'b1;

        // Acquire: vfall 1..3 train, vfall 4 locks, frame_start from vfall 5.
        repeat (3) send_rows(0, V, 0, -1);
        check_lock("pre_lock", 0, 0, 0);
        send_line(0, 0, 1, 0);
        check_lock("lock_4th_vfall", 1, H, V);
        send_line(0, 1, H, 0);
        send_rows(1, V, 0, -1);
        repeat (2) send_rows(0, V, 1, -1);
        check_lock("locked_steady", 1, H, V);

        // One short line breaks lock on its closing hfall.
        send_rows(0, 8, 1, 7);
        check_lock("before_short_hfall", 1, H, V);
        send_line(8, 0, 1, 0);
        check_lock("short_line_unlock", 0, H, V);
        send_line(8, 1, H, 0);
        send_rows(9, V, 0, -1);
        repeat (3) send_rows(0, V, 0, -1);
        check_lock("relock_pending", 0, H, V);
        send_line(0, 0, 1, 0);
        check_lock("relock", 1, H, V);
        send_line(0, 1, H, 0);
        send_rows(1, V, 0, -1);
        send_rows(0, V, 1, -1);

        // h_sync stuck high: last hfall 39 ticks ago, ceiling hit on tick 984.
        repeat (983) tick(1, 1, 0, 0, 0, 0, 0);
        check_lock("pre_timeout", 1, H, V);
        tick(1, 1, 0, 0, 0, 0, 0);
        check_lock("h_timeout", 0, H, V);
        for (int i = 0; i < 5; i++) tick(1, 1, 1, 0, 0, i, VACT);
        repeat (3) tick(1, 1, 0, 0, 0, 0, 0);

        // Relock, then a one-cycle reset in the vertical blank of a locked frame.
        repeat (3) send_rows(0, V, 0, -1);
        send_line(0, 0, 1, 0);
        check_lock("relock_after_timeout", 1, H, V);
        send_line(0, 1, H, 0);
        send_rows(1, V, 0, -1);
        send_rows(0, 3, 1, -1);
        send_line(3, 0, 20, 0);
        rst_n = 1'b0; clk_div2 = 1'b1;
        @(posedge clk0); #1;
        rst_n = 1'b1; clk_div2 = 1'b0;
        @(negedge clk0);
        check("midrst_pixel_valid", pixel_valid, 0);
        check("midrst_pos", {pos_x, pos_y}, 0);
        check("midrst_pulses", {line_start, frame_start}, 0);
        check_lock("midrst", 0, 0, 0);

        // Freeze mid-line with the tick enable held low while inputs toggle.
        send_line(3, 20, H, 0);
        send_line(4, 0, H, 0);
        send_line(5, 0, HA0 + 10, 0);
        for (int i = 0; i < 50; i++) begin
            h_sync = 1'($urandom); v_sync = 1'($urandom); blank_n = 1'($urandom);
            @(negedge clk0);
            check("hold_pixel_valid", pixel_valid, 1);
            check("hold_pos_x", pos_x, 9);
            check("hold_pos_y", pos_y, 0);
            check("hold_locked", locked, 0);
        end
        send_line(5, HA0 + 10, H, 0);
        send_rows(6, V, 0, -1);
        send_rows(0, V, 0, -1);
        check_lock("post_reset", 0, 0, 0);

        repeat (4) @(negedge clk0);
        check("tick_q_drain", pl_q.size(), 0);
        check("px_q_drain", px_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
